pc_fetch: RTL

Program-counter and instruction-fetch stage that sits directly downstream of the return-address-stack controller. It owns the architectural PC register and takes redirect targets (`pc_jmp`, `muxras`) from the RAS controller. It issues word fetches to instruction memory over a req/ack handshake and hands one buffered instruction at a time to the decoder. It is the stage that consumes the RAS controller's outputs and feeds the decoder that drives `ras_en`.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/redirect_detect.sv | 22 ++
 rtl/pc_fetch.sv | 120 ++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - fetch stage state encodings and constants
package fetch_pkg;

    typedef logic [2:0] fetch_state_t;

    localparam fetch_state_t ST_IDLE = 3'd0;
    localparam fetch_state_t ST_REQ  = 3'd1;
    localparam fetch_state_t ST_KILL = 3'd2;
    localparam fetch_state_t ST_HOLD = 3'd3;
    localparam fetch_state_t ST_HALT = 3'd4;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;
    localparam logic [31:0] PC_INC   = 32'd4;

endpackage

// File: rtl/redirect_detect.sv
// rtl/redirect_detect.sv - rising-edge detector on the RAS redirect select
module redirect_detect (
    input  logic clk,
    input  logic rst,
    input  logic muxras,
    output logic redir
);

    logic muxras_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            muxras_q <= 1'b0;
        end else begin
            muxras_q <= muxras;
        end
    end

    // The RAS holds muxras as a level; only its first cycle is a redirect.
    assign redir = muxras & ~muxras_q;

endmodule

// File: rtl/pc_fetch.sv
// rtl/pc_fetch.sv - PC register and single-outstanding fetch stage (FETCH_MISALIGN_CHECK_EN adds misaligned-redirect halt)
module pc_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_jmp,
    input  logic        muxras,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc,
    output logic        misalign
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  jmp_target;
    logic         jmp_bad;
    logic         redir;

    redirect_detect u_redirect_detect (
        .clk    (clk),
        .rst    (rst),
        .muxras (muxras),
        .redir  (redir)
    );

`ifdef FETCH_MISALIGN_CHECK_EN
    logic misalign_q;

    assign jmp_target = pc_jmp;
    assign jmp_bad    = redir & (pc_jmp[1:0] != 2'b00);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else if (jmp_bad) begin
            misalign_q <= 1'b1;
        end
    end

    assign misalign = misalign_q;
`else
    assign jmp_target = pc_jmp & ~32'h0000_0003;
    assign jmp_bad    = 1'b0;
    assign misalign   = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            pc         <= RESET_PC;
            inst_valid <= 1'b0;
            inst_out   <= NOP_INST;
            inst_pc    <= 32'h0000_0000;
        end else if (jmp_bad) begin
            state      <= ST_HALT;
            inst_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state <= ST_REQ;
                    if (redir) begin
                        pc <= jmp_target;
                    end
                end
                ST_REQ: begin
                    // A redirect alongside an ack drops the data and re-requests at once.
                    if (redir) begin
                        pc    <= jmp_target;
                        state <= imem_ack ? ST_REQ : ST_KILL;
                    end else if (imem_ack) begin
                        inst_out   <= imem_rdata;
                        inst_pc    <= pc;
                        inst_valid <= 1'b1;
                        pc         <= pc + PC_INC;
                        state      <= ST_HOLD;
                    end
                end
                ST_KILL: begin
                    if (redir) begin
                        pc <= jmp_target;
                    end
                    if (imem_ack) begin
                        state <= ST_REQ;
                    end
                end
                ST_HOLD: begin
                    if (redir) begin
                        inst_valid <= 1'b0;
                        pc         <= jmp_target;
                        state      <= ST_REQ;
                    end else if (!stall) begin
                        inst_valid <= 1'b0;
                        state      <= ST_REQ;
                    end
                end
`ifdef FETCH_MISALIGN_CHECK_EN
                ST_HALT: begin
                    state <= ST_HALT;
                end
`endif
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign imem_req  = (state == ST_REQ);
    assign imem_addr = pc;

endmodule
